uart_tx_buffered: RTL and testbench

- Serial UART transmitter. Sends 8 data bits LSB first, framed by one start bit and 1 or 2 stop bits, with an optional parity bit.
- Double-buffered in MC68681 style: a one-byte holding register sits in front of the shift register, so the host can queue the next byte while the current frame is on the line.
- Sits between the channel register interface (THR write) and the TxD pin. It is the counterpart of the channel receiver and uses the same CLKS_PER_BIT convention.

---
 rtl/uart_tx_buffered.sv | 185 ++++++++++++++++++
 tb/tb_uart_tx_buffered.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_buffered.sv
// uart_tx_buffered: double-buffered serial UART transmitter.
// Frame: 1 start bit, 8 data bits LSB first, optional parity bit, 1 or 2 stop bits.
// A one-byte holding register in front of the shifter lets the host queue the next
// byte while the current frame is on the line (TxRDY / TxEMT style status).
// Optional feature macro: UART_TX_PARITY_EN adds i_Parity_Odd and a PARITY bit time.
module uart_tx_buffered #(
  parameter int CLKS_PER_BIT = 417
) (
  input  logic       i_Clock,
  input  logic       i_Rst_L,
  input  logic       i_TX_DV,
  input  logic [7:0] i_TX_Byte,
  input  logic       i_Two_Stop,
`ifdef UART_TX_PARITY_EN
  input  logic       i_Parity_Odd,
`endif
  output logic       o_TX_Serial,
  output logic       o_TX_Active,
  output logic       o_TX_Ready,
  output logic       o_TX_Empty,
  output logic       o_TX_Done,
  output logic       o_TX_Overrun
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_TX_PARITY_EN
    S_PARITY,
`endif
    S_STOP1,
    S_STOP2
  } state_t;

  state_t           state_reg;
  logic [CNT_W-1:0] clk_cnt_reg;
  logic [2:0]       bit_idx_reg;
  logic [7:0]       shift_reg;
  logic [7:0]       hold_byte_reg;
  logic             two_stop_reg;
`ifdef UART_TX_PARITY_EN
  logic             parity_bit_reg;
`endif
  logic             serial_reg;
  logic             active_reg;
  logic             ready_reg;
  logic             empty_reg;
  logic             done_reg;
  logic             overrun_reg;

  logic bit_end;
  logic last_stop;
  logic transfer;
  logic accept;
  logic hold_valid_next;
  logic idle_next;

  // Frame-boundary and holding-register decisions for the coming edge.
  // The holding register is full exactly when ready_reg is low.
  always_comb begin
    bit_end         = (clk_cnt_reg == CNT_MAX);
    last_stop       = bit_end &&
                      (((state_reg == S_STOP1) && !two_stop_reg) || (state_reg == S_STOP2));
    transfer        = !ready_reg && ((state_reg == S_IDLE) || last_stop);
    accept          = i_TX_DV && ready_reg;
    hold_valid_next = transfer ? 1'b0 : (accept ? 1'b1 : !ready_reg);
    idle_next       = !transfer && ((state_reg == S_IDLE) || last_stop);
  end

  // Transmit FSM, holding register and all registered status outputs.
  always_ff @(posedge i_Clock or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state_reg      <= S_IDLE;
      clk_cnt_reg    <= '0;
      bit_idx_reg    <= '0;
      shift_reg      <= '0;
      hold_byte_reg  <= '0;
      two_stop_reg   <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_bit_reg <= 1'b0;
`endif
      serial_reg     <= 1'b1;
      active_reg     <= 1'b0;
      ready_reg      <= 1'b1;
      empty_reg      <= 1'b1;
      done_reg       <= 1'b0;
      overrun_reg    <= 1'b0;
    end else begin
      done_reg    <= last_stop;
      overrun_reg <= i_TX_DV && !ready_reg;
      ready_reg   <= !hold_valid_next;
      empty_reg   <= !hold_valid_next && idle_next;
      active_reg  <= !idle_next;

      if (accept) begin
        hold_byte_reg <= i_TX_Byte;
      end

      if (transfer) begin
        // Load the shifter and start the frame; the line drops on this edge.
        shift_reg      <= hold_byte_reg;
        two_stop_reg   <= i_Two_Stop;
`ifdef UART_TX_PARITY_EN
        parity_bit_reg <= (^hold_byte_reg) ^ i_Parity_Odd;
`endif
        state_reg      <= S_START;
        clk_cnt_reg    <= '0;
        bit_idx_reg    <= '0;
        serial_reg     <= 1'b0;
      end else begin
        if (state_reg == S_IDLE || bit_end) begin
          clk_cnt_reg <= '0;
        end else begin
          clk_cnt_reg <= clk_cnt_reg + CNT_W'(1);
        end

        case (state_reg)
          S_IDLE: begin
            serial_reg <= 1'b1;
          end
          S_START: begin
            if (bit_end) begin
              state_reg   <= S_DATA;
              bit_idx_reg <= '0;
              serial_reg  <= shift_reg[0];
            end
          end
          S_DATA: begin
            if (bit_end) begin
              if (bit_idx_reg == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                state_reg  <= S_PARITY;
                serial_reg <= parity_bit_reg;
`else
                state_reg  <= S_STOP1;
                serial_reg <= 1'b1;
`endif
              end else begin
                bit_idx_reg <= bit_idx_reg + 3'd1;
                shift_reg   <= {1'b0, shift_reg[7:1]};
                serial_reg  <= shift_reg[1];
              end
            end
          end
`ifdef UART_TX_PARITY_EN
          S_PARITY: begin
            if (bit_end) begin
              state_reg  <= S_STOP1;
              serial_reg <= 1'b1;
            end
          end
`endif
          S_STOP1: begin
            serial_reg <= 1'b1;
            if (bit_end) begin
              state_reg <= two_stop_reg ? S_STOP2 : S_IDLE;
            end
          end
          S_STOP2: begin
            serial_reg <= 1'b1;
            if (bit_end) begin
              state_reg <= S_IDLE;
            end
          end
          default: begin
            state_reg  <= S_IDLE;
            serial_reg <= 1'b1;
          end
        endcase
      end
    end
  end

  assign o_TX_Serial  = serial_reg;
  assign o_TX_Active  = active_reg;
  assign o_TX_Ready   = ready_reg;
  assign o_TX_Empty   = empty_reg;
  assign o_TX_Done    = done_reg;
  assign o_TX_Overrun = overrun_reg;

endmodule

// File: tb/tb_uart_tx_buffered.sv
// tb_uart_tx_buffered: table-driven frame checks plus hand sequences for
// back-to-back frames, overrun and mid-frame reset. A line monitor decodes
// every frame and compares it with the byte queued when it was written.
module tb_uart_tx_buffered;

  localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int STOP_SAMPLE = (10 + PAR) * CPB - 2;
  localparam int FRAME_LAST  = (10 + PAR) * CPB - 1;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       dv = 1'b0;
  logic [7:0] tx_byte = 8'h00;
  logic       two_stop = 1'b0;
  logic       parity_odd = 1'b0;
  logic       serial, active, ready, empty, done, overrun;

  uart_tx_buffered #(.CLKS_PER_BIT(CPB)) dut (
    .i_Clock      (clk),
    .i_Rst_L      (rst_n),
    .i_TX_DV      (dv),
    .i_TX_Byte    (tx_byte),
    .i_Two_Stop   (two_stop),
`ifdef UART_TX_PARITY_EN
    .i_Parity_Odd (parity_odd),
`endif
    .o_TX_Serial  (serial),
    .o_TX_Active  (active),
    .o_TX_Ready   (ready),
    .o_TX_Empty   (empty),
    .o_TX_Done    (done),
    .o_TX_Overrun (overrun)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  logic [7:0] sb[$];
  int done_cnt = 0;
  int ovr_cnt = 0;
  int frames = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Line monitor: samples mid-bit on the falling edge and checks each frame.
  int mon_cnt = 0;
  logic mon_busy = 1'b0;
  logic [7:0] mon_byte = 8'h00;
  always @(negedge clk) begin
    if (!rst_n) begin
      mon_busy = 1'b0;
      mon_cnt  = 0;
    end else begin
      if (done) done_cnt++;
      if (overrun) ovr_cnt++;
      if (!mon_busy) begin
        if (serial == 1'b0) begin
          mon_busy = 1'b1;
          mon_cnt  = 0;
        end
      end else begin
        mon_cnt++;
      end
      if (mon_busy) begin
        if (mon_cnt == 2) check("start_bit", serial, 0);
        if (mon_cnt >= 6 && mon_cnt <= 34 && ((mon_cnt - 6) % 4) == 0)
          mon_byte[(mon_cnt - 6) / 4] = serial;
`ifdef UART_TX_PARITY_EN
        if (mon_cnt == 38) check("parity_bit", serial, (^mon_byte) ^ parity_odd);
`endif
        if (mon_cnt == STOP_SAMPLE) begin
          check("stop_bit", serial, 1);
          checks++;
          if (sb.size() == 0) begin
            errors++;
            $display("FAIL sb_unexpected: got byte %02h expected no frame", mon_byte);
          end else begin
            logic [7:0] exp_b;
            exp_b = sb.pop_front();
            if (mon_byte !== exp_b) begin
              errors++;
              $display("FAIL sb_data: got %02h expected %02h", mon_byte, exp_b);
            end
            $display("frame %0d: byte %02h", frames, mon_byte);
          end
          frames++;
        end
        if (mon_cnt == FRAME_LAST) mon_busy = 1'b0;
      end
    end
  end

  task automatic write_byte(input logic [7:0] b, input bit push);
    @(negedge clk);
    dv = 1'b1;
    tx_byte = b;
    if (push) sb.push_back(b);
    @(negedge clk);
    dv = 1'b0;
  endtask

  task automatic wait_ready(input int budget);
    int k;
    for (k = 0; k < budget; k++) begin
      @(negedge clk);
      if (ready) break;
    end
    check("wait_ready_timeout", (k < budget) ? 1 : 0, 1);
  endtask

  task automatic wait_idle(input int budget);
    int k;
    for (k = 0; k < budget; k++) begin
      @(negedge clk);
      if (empty && ready && !active) break;
    end
    check("wait_idle_timeout", (k < budget) ? 1 : 0, 1);
  endtask

  typedef struct {
    logic [7:0] b;
    logic       ts;
    int         exp_len;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int base_done, base_ovr, base_frames, len;

    vecs[0] = '{8'hA5, 1'b0, CPB * (10 + PAR)};
    vecs[1] = '{8'h00, 1'b1, CPB * (11 + PAR)};
    vecs[2] = '{8'h07, 1'b0, CPB * (10 + PAR)};
    vecs[3] = '{8'hFF, 1'b1, CPB * (11 + PAR)};
    vecs[4] = '{8'h3C, 1'b0, CPB * (10 + PAR)};
    vecs[5] = '{8'h80, 1'b1, CPB * (11 + PAR)};

    // Reset state and quiet idle.
    repeat (3) @(negedge clk);
    check("rst_serial", serial, 1);
    check("rst_active", active, 0);
    check("rst_ready", ready, 1);
    check("rst_empty", empty, 1);
    check("rst_done", done, 0);
    check("rst_overrun", overrun, 0);
    rst_n = 1'b1;
    repeat (50) @(negedge clk);
    check("idle_serial", serial, 1);
    check("idle_ready", ready, 1);
    check("idle_empty", empty, 1);
    check("idle_done_cnt", done_cnt, 0);

    // Table-driven single frames: latency, frame length, status afterwards.
    for (int i = 0; i < 6; i++) begin
      two_stop = vecs[i].ts;
      write_byte(vecs[i].b, 1'b1);
      check("lat_pre_serial", serial, 1);
      check("lat_pre_ready", ready, 0);
      @(negedge clk);
      check("lat_start_serial", serial, 0);
      check("lat_start_ready", ready, 1);
      check("lat_start_active", active, 1);
      check("lat_start_empty", empty, 0);
      len = 0;
      for (int k = 1; k <= 200; k++) begin
        @(negedge clk);
        if (done) begin
          len = k;
          break;
        end
      end
      check("frame_len", len, vecs[i].exp_len);
      check("end_empty", empty, 1);
      check("end_active", active, 0);
      @(negedge clk);
      check("done_one_cycle", done, 0);
      $display("vector %0d: byte %02h two_stop %0d len %0d", i, vecs[i].b, vecs[i].ts, len);
    end

    // Back-to-back frames: no idle cycle between stop and next start.
    two_stop = 1'b0;
    base_done = done_cnt;
    write_byte(8'h01, 1'b1);
    wait_ready(20);
    write_byte(8'hFF, 1'b1);
    len = 0;
    for (int k = 1; k <= 200; k++) begin
      @(negedge clk);
      if (done) begin
        len = k;
        break;
      end
    end
    check("b2b_done_seen", (len > 0) ? 1 : 0, 1);
    check("b2b_no_gap_serial", serial, 0);
    check("b2b_active", active, 1);
    wait_idle(200);
    repeat (2) @(negedge clk);
    check("b2b_done_count", done_cnt - base_done, 2);

    // Overrun: third write while the holding register is full is dropped.
    base_ovr = ovr_cnt;
    base_frames = frames;
    write_byte(8'h55, 1'b1);
    wait_ready(20);
    write_byte(8'h33, 1'b1);
    write_byte(8'h77, 1'b0);
    wait_idle(300);
    repeat (2) @(negedge clk);
    check("ovr_count", ovr_cnt - base_ovr, 1);
    check("ovr_frames", frames - base_frames, 2);
    check("ovr_sb_empty", sb.size(), 0);

`ifdef UART_TX_PARITY_EN
    // Even parity of 0x07 (three ones) gives a parity bit of 1.
    parity_odd = 1'b0;
    write_byte(8'h07, 1'b1);
    repeat (1 + 9 * CPB + 2) @(negedge clk);
    check("parity_07_even", serial, 1);
    wait_idle(200);
`endif

    // Reset in the middle of the data bits aborts the frame immediately.
    base_done = done_cnt;
    write_byte(8'h00, 1'b1);
    repeat (10) @(negedge clk);
    check("mid_data_low", serial, 0);
    rst_n = 1'b0;
    #1;
    check("abort_serial", serial, 1);
    check("abort_active", active, 0);
    check("abort_ready", ready, 1);
    check("abort_empty", empty, 1);
    sb.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (50) @(negedge clk);
    check("post_rst_done", done_cnt - base_done, 0);
    check("post_rst_ready", ready, 1);
    check("post_rst_empty", empty, 1);
    check("post_rst_serial", serial, 1);
    check("final_sb_empty", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule
